// File: rtl/wb_pkg.sv
// Shared types for the Wishbone master bridge: FSM state encoding and the
// captured request record.
package wb_pkg;

  localparam int WB_DATA_W     = 32;
  localparam int WB_SEL_W      = 4;
  // Request record carries the widest supported address; the bridge uses
  // the low WB_ADDR_W bits.
  localparam int WB_ADDR_W_MAX = 64;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    XFER,
    BACKOFF,
    RESP,
    HOLD
  } wb_mst_state_e;

  typedef struct packed {
    logic [WB_ADDR_W_MAX-1:0] addr;
    logic                     we;
    logic [WB_DATA_W-1:0]     wdata;
    logic [WB_SEL_W-1:0]      be;
    logic                     lock;
  } wb_req_t;

endpackage

// File: rtl/wb_timeout_cnt.sv
// Saturating cycle counter. expired_o rises once LIMIT-1 enabled cycles
// have elapsed since the last clear, so an owner that leaves its state on
// expired_o spends exactly LIMIT cycles there.
module wb_timeout_cnt #(
  parameter int LIMIT = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int              CW   = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0]   LAST = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_q;

  // Count enabled cycles, hold at LAST, restart on clear.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i)             cnt_q <= '0;
    else if (en_i && !expired_o)    cnt_q <= cnt_q + 1'b1;
  end

  assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/wb_master_bridge.sv
// Valid/ready request port to Wishbone classic single-beat master.
// One request in flight; handles arbitration, preemption, retry with
// backoff, slave error, timeout and locked back-to-back accesses.
module wb_master_bridge
  import wb_pkg::*;
#(
  parameter int TAGSIZE       = 2,
  parameter int WB_ADDR_W     = 32,
  parameter int MAX_RETRY     = 4,
  parameter int RETRY_BACKOFF = 8,
  parameter int TIMEOUT       = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  // request port
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [WB_ADDR_W-1:0] req_addr_i,
  input  logic                 req_we_i,
  input  logic [31:0]          req_wdata_i,
  input  logic [3:0]           req_be_i,
  input  logic                 req_lock_i,
  // response port
  output logic                 rsp_valid_o,
  output logic [31:0]          rsp_rdata_o,
  output logic                 rsp_err_o,
  // wishbone master
  output logic                 wb_cyc_o,
  output logic                 wb_stb_o,
  output logic                 wb_we_o,
  output logic                 wb_lock_o,
  output logic [WB_ADDR_W-1:0] wb_adr_o,
  output logic [31:0]          wb_dat_o,
  output logic [3:0]           wb_sel_o,
  output logic [TAGSIZE-1:0]   wb_tga_o,
  output logic [TAGSIZE-1:0]   wb_tgc_o,
  output logic [TAGSIZE-1:0]   wb_tgd_o,
  input  logic [31:0]          wb_dat_i,
  input  logic [TAGSIZE-1:0]   wb_tgd_i,
  input  logic                 wb_ack_i,
  input  logic                 wb_err_i,
  input  logic                 wb_rty_i,
  input  logic                 wb_gnt_i
);

  localparam int            RW         = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);

  wb_mst_state_e state_q;
  wb_req_t       req_q;
  logic [RW-1:0] retry_q;
  logic          err_q;
  logic [31:0]   rdata_q;

  logic accept;
  logic qual;
  logic tmo_expired;
  logic bko_expired;

  assign accept = req_valid_i && req_ready_o;
  // Slave responses only count while we own the bus and strobe; this drops
  // stale acks that straddle a grant change.
  assign qual   = wb_gnt_i && wb_stb_o;

  wb_timeout_cnt #(.LIMIT(TIMEOUT)) u_tmo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (state_q != XFER),
    .en_i     (state_q == XFER),
    .expired_o(tmo_expired)
  );

  wb_timeout_cnt #(.LIMIT(RETRY_BACKOFF)) u_bko (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (state_q != BACKOFF),
    .en_i     (state_q == BACKOFF),
    .expired_o(bko_expired)
  );

  // Request capture, bus FSM, retry count and response registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      req_q   <= '0;
      retry_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        req_q <= '{addr:  WB_ADDR_W_MAX'(req_addr_i),
                   we:    req_we_i,
                   wdata: req_wdata_i,
                   be:    req_be_i,
                   lock:  req_lock_i};
      end
      unique case (state_q)
        IDLE: if (accept) state_q <= REQ;
        REQ:  if (wb_gnt_i) state_q <= XFER;
        XFER: begin
          if (!wb_gnt_i) begin
            // preempted: re-arbitrate, not a retry
            state_q <= REQ;
          end else if (qual && wb_err_i) begin
            state_q <= RESP;
            err_q   <= 1'b1;
            rdata_q <= '0;
          end else if (qual && wb_ack_i) begin
            state_q <= RESP;
            err_q   <= 1'b0;
            rdata_q <= req_q.we ? 32'h0 : wb_dat_i;
          end else if (qual && wb_rty_i) begin
            if (retry_q == RETRY_LAST) begin
              state_q <= RESP;
              err_q   <= 1'b1;
              rdata_q <= '0;
            end else begin
              retry_q <= retry_q + 1'b1;
              state_q <= BACKOFF;
            end
          end else if (tmo_expired) begin
            state_q <= RESP;
            err_q   <= 1'b1;
            rdata_q <= '0;
          end
        end
        BACKOFF: if (bko_expired) state_q <= REQ;
        RESP: begin
          retry_q <= '0;
          state_q <= (req_q.lock && !err_q) ? HOLD : IDLE;
        end
        HOLD: begin
          // grant is retained while locked, so a new request skips REQ
          if (accept)         state_q <= wb_gnt_i ? XFER : REQ;
          else if (!wb_gnt_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs decode the state and request flops only: no input-to-output paths.
  assign req_ready_o = (state_q == IDLE) || (state_q == HOLD);
  assign wb_stb_o    = (state_q == XFER);
  assign wb_cyc_o    = (state_q == REQ) || (state_q == XFER) || (state_q == HOLD) ||
                       ((state_q == RESP) && req_q.lock && !err_q);
  assign wb_lock_o   = req_q.lock && wb_cyc_o;
  assign wb_we_o     = req_q.we;
  assign wb_adr_o    = req_q.addr[WB_ADDR_W-1:0];
  assign wb_dat_o    = req_q.wdata;
  assign wb_sel_o    = req_q.be;
  assign wb_tga_o    = '0;
  assign wb_tgc_o    = '0;
  assign wb_tgd_o    = '0;

  assign rsp_valid_o = (state_q == RESP);
  assign rsp_rdata_o = rsp_valid_o ? rdata_q : 32'h0;
  assign rsp_err_o   = rsp_valid_o && err_q;

  // Tag input and spare address bits carry nothing for this master.
  logic unused_ok;
  assign unused_ok = ^{wb_tgd_i, req_q.addr};

endmodule

// File: tb/tb_wb_master_bridge.sv
// Bench for wb_master_bridge: directed scenarios plus randomized slave and
// arbiter behaviour, checked against an outcome model of the bridge.
module tb_wb_master_bridge;

  localparam int TAGSIZE = 2, AW = 32, MAX_RETRY = 4, RETRY_BACKOFF = 8, TIMEOUT = 256;
  localparam int F_ACK = 0, F_ERR = 1, F_NONE = 2;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic req_valid_i = 1'b0, req_ready_o;
  logic [AW-1:0] req_addr_i = '0;
  logic req_we_i = 1'b0, req_lock_i = 1'b0;
  logic [31:0] req_wdata_i = '0;
  logic [3:0] req_be_i = '0;
  logic rsp_valid_o, rsp_err_o;
  logic [31:0] rsp_rdata_o;
  logic wb_cyc_o, wb_stb_o, wb_we_o, wb_lock_o;
  logic [AW-1:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0] wb_sel_o;
  logic [TAGSIZE-1:0] wb_tga_o, wb_tgc_o, wb_tgd_o;
  logic [31:0] wb_dat_i = '0;
  logic [TAGSIZE-1:0] wb_tgd_i = '0;
  logic wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0, wb_gnt_i = 1'b0;

  int n_vec = 0, n_err = 0;
  int cyc_age = 0, stb_age = 0;
  bit held = 1'b0;

  always #5 clk_i = ~clk_i;

  wb_master_bridge #(.TAGSIZE(TAGSIZE), .WB_ADDR_W(AW), .MAX_RETRY(MAX_RETRY),
                     .RETRY_BACKOFF(RETRY_BACKOFF), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_we_i(req_we_i), .req_wdata_i(req_wdata_i), .req_be_i(req_be_i), .req_lock_i(req_lock_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_lock_o(wb_lock_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_tga_o(wb_tga_o), .wb_tgc_o(wb_tgc_o), .wb_tgd_o(wb_tgd_o),
    .wb_dat_i(wb_dat_i), .wb_tgd_i(wb_tgd_i),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i), .wb_gnt_i(wb_gnt_i)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  // One request through the bridge. The arbiter grants gnt_dly cycles after
  // cyc rises; the slave answers wait_st cycles into each strobe with n_rty
  // retries and then the final outcome fin. stray injects an ack while cyc is
  // up without grant; preempt pulls grant for two cycles at the first strobe.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input logic lock, input int n_rty, input int fin,
                         input int gnt_dly, input int wait_st, input logic [31:0] rdat,
                         input bit stray, input bit preempt);
    bit exp_err, exp_hold, seen_cyc, preempted, stray_done, resp_done, chk_drop;
    logic [31:0] exp_rdata, got_rdata;
    logic got_err;
    int exp_win, exp_first, c, first_stb, last_rise, rsp_c, nwin, low_run, rty_left, drop;
    // outcome model
    exp_err   = (fin != F_ACK) || (n_rty > MAX_RETRY);
    exp_rdata = (!exp_err && !we) ? rdat : 32'h0;
    exp_win   = (n_rty > MAX_RETRY) ? MAX_RETRY : n_rty;
    exp_hold  = lock && !exp_err;
    exp_first = held ? 1 : gnt_dly + 2;
    c = 0; first_stb = -1; last_rise = -1; rsp_c = -1; nwin = 0; low_run = 0;
    rty_left = n_rty; drop = 0;
    seen_cyc = 0; preempted = 0; stray_done = 0; resp_done = 0; chk_drop = 0;
    got_rdata = '0; got_err = 1'b0;

    req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr; req_wdata_i = wdata;
    req_be_i = be; req_lock_i = lock;
    chk("req_ready_at_issue", req_ready_o, 1);
    while (rsp_c < 0 && c < 1200) begin
      // observe this cycle
      if (wb_cyc_o) begin
        if (seen_cyc && low_run > 0) begin
          nwin++;
          chk("backoff_len", low_run, RETRY_BACKOFF);
        end
        low_run = 0; seen_cyc = 1; cyc_age++;
      end else begin
        if (seen_cyc) low_run++;
        cyc_age = 0;
      end
      if (chk_drop) begin
        chk("preempt_stb_drop", wb_stb_o, 0);
        chk_drop = 0;
      end
      if (wb_stb_o) begin
        if (stb_age == 0) begin
          if (first_stb < 0) begin
            first_stb = c;
            chk("stb_latency", c, exp_first);
            chk("wb_adr", wb_adr_o, addr);
            chk("wb_we", wb_we_o, we);
            chk("wb_sel", wb_sel_o, be);
            if (we) chk("wb_dat", wb_dat_o, wdata);
          end
          last_rise = c;
        end
        stb_age++;
      end else stb_age = 0;
      if (rsp_valid_o) begin
        rsp_c = c; got_rdata = rsp_rdata_o; got_err = rsp_err_o;
      end
      // drive arbiter and slave for this cycle
      if (wb_stb_o && preempt && !preempted) begin
        drop = 2; preempted = 1; chk_drop = 1;
      end
      wb_gnt_i = wb_cyc_o && (cyc_age > gnt_dly) && (drop == 0);
      if (drop > 0) drop--;
      wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0; wb_dat_i = $urandom;
      if (stray && !stray_done && wb_cyc_o && !wb_gnt_i) begin
        wb_ack_i = 1; stray_done = 1;
      end else if (wb_stb_o && wb_gnt_i && stb_age > wait_st && !resp_done) begin
        if (rty_left > 0) begin
          wb_rty_i = 1; rty_left--;
        end else if (fin == F_ERR) begin
          wb_err_i = 1; wb_ack_i = 1'($urandom % 2); resp_done = 1;
        end else if (fin == F_ACK) begin
          wb_ack_i = 1; wb_dat_i = rdat; resp_done = 1;
        end
      end
      if (rsp_c >= 0) break;
      tick; c++;
      req_valid_i = 1'b0;
    end

    if (rsp_c < 0) begin
      chk("rsp_within_bound", 0, 1);
    end else begin
      chk("rsp_err", got_err, exp_err);
      chk("rsp_rdata", got_rdata, exp_rdata);
      chk("backoff_windows", nwin, exp_win);
      if (fin == F_NONE && n_rty <= MAX_RETRY) chk("timeout_cycles", rsp_c - last_rise, TIMEOUT);
      if (n_rty == 0 && !preempt && fin != F_NONE) chk("rsp_latency", rsp_c - first_stb, wait_st + 1);
      tick;
      chk("rsp_single_pulse", rsp_valid_o, 0);
      chk("post_cyc", wb_cyc_o, exp_hold);
      chk("post_lock", wb_lock_o, exp_hold);
      chk("post_ready", req_ready_o, 1);
    end
    held = exp_hold;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic r_we, r_lock;
    logic [31:0] r_addr, r_wdata, r_rdat;
    logic [3:0] r_be;
    int r_fin, r_rty, r_sel;

    // reset state
    tick; tick;
    chk("rst_wb_ctrl", {wb_cyc_o, wb_stb_o, wb_we_o, wb_lock_o}, 0);
    chk("rst_wb_adr", wb_adr_o, 0);
    chk("rst_wb_dat_sel", {wb_dat_o, wb_sel_o}, 0);
    chk("rst_wb_tags", {wb_tga_o, wb_tgc_o, wb_tgd_o}, 0);
    chk("rst_rsp", {rsp_valid_o, rsp_err_o, rsp_rdata_o}, 0);
    chk("rst_ready", req_ready_o, 1);
    rst_i = 1'b0;
    tick;

    // zero-wait read, grant one cycle after cyc
    run_txn(0, 32'h1000_0040, 32'h0, 4'hF, 0, 0, F_ACK, 1, 0, 32'hDEAD_BEEF, 0, 0);
    // write with a stale ack one cycle before grant
    run_txn(1, 32'h2000_0008, 32'hCAFE_F00D, 4'b0011, 0, 0, F_ACK, 1, 1, 32'h1234_5678, 1, 0);
    // three retries then ack; five retries give up with error
    run_txn(0, 32'h3000_0000, 32'h0, 4'hF, 0, 3, F_ACK, 1, 0, 32'h0BAD_C0DE, 0, 0);
    run_txn(0, 32'h3000_0004, 32'h0, 4'hF, 0, 5, F_ACK, 1, 0, 32'h5555_AAAA, 0, 0);
    // grant pulled mid-transfer
    run_txn(0, 32'h4000_0010, 32'h0, 4'hF, 0, 0, F_ACK, 2, 2, 32'hA5A5_5A5A, 0, 1);
    // slave error with ack on the same cycle
    run_txn(0, 32'h4000_0020, 32'h0, 4'hF, 0, 0, F_ERR, 1, 1, 32'h7777_7777, 0, 0);
    // silent slave
    run_txn(1, 32'h5000_0000, 32'h1111_2222, 4'hC, 0, 0, F_NONE, 1, 0, 32'h0, 0, 0);
    // locked pair: bus kept, second strobe one cycle after accept
    run_txn(0, 32'h6000_0000, 32'h0, 4'hF, 1, 0, F_ACK, 1, 0, 32'h0102_0304, 0, 0);
    run_txn(1, 32'h6000_0004, 32'h0A0B_0C0D, 4'hF, 0, 0, F_ACK, 3, 1, 32'h0, 0, 0);
    // grant lost while holding
    run_txn(1, 32'h6000_0008, 32'hFEED_FACE, 4'h1, 1, 0, F_ACK, 1, 0, 32'h0, 0, 0);
    wb_gnt_i = 1'b0;
    tick;
    chk("hold_gnt_loss_cyc", {wb_cyc_o, wb_lock_o}, 0);
    chk("hold_gnt_loss_ready", req_ready_o, 1);
    held = 1'b0; cyc_age = 0;

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      r_we = 1'($urandom % 2);
      r_lock = 1'($urandom % 4 == 0);
      r_addr = $urandom & 32'hFFFF_FFFC;
      r_wdata = $urandom; r_rdat = $urandom;
      r_be = 4'($urandom_range(1, 15));
      r_sel = $urandom % 16;
      r_fin = (r_sel < 11) ? F_ACK : (r_sel < 15) ? F_ERR : F_NONE;
      r_rty = ($urandom % 4 == 0) ? $urandom_range(1, 5) : 0;
      run_txn(r_we, r_addr, r_wdata, r_be, r_lock, r_rty, r_fin, $urandom_range(1, 3),
              $urandom_range(0, 3), r_rdat, bit'($urandom % 4 == 0), bit'($urandom % 5 == 0));
      if (!held) repeat ($urandom % 3) tick;
    end
    if (held) begin
      wb_gnt_i = 1'b0;
      tick;
      held = 1'b0; cyc_age = 0;
    end

    // reset in the middle of a transfer
    tick;
    req_valid_i = 1'b1; req_we_i = 1'b0; req_lock_i = 1'b1; req_addr_i = 32'h7000_0000;
    tick;
    req_valid_i = 1'b0; wb_gnt_i = 1'b1; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
    tick;
    chk("midrst_in_xfer", wb_stb_o, 1);
    rst_i = 1'b1;
    tick;
    chk("midrst_wb", {wb_cyc_o, wb_stb_o, wb_lock_o, wb_adr_o}, 0);
    chk("midrst_rsp", {rsp_valid_o, rsp_err_o, rsp_rdata_o}, 0);
    chk("midrst_ready", req_ready_o, 1);
    rst_i = 1'b0; wb_gnt_i = 1'b0;
    tick;
    chk("midrst_no_rsp", {rsp_valid_o, wb_cyc_o}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
